// File: rtl/bcd_updown_counter_n_pkg.sv
// Shared BCD constants and helpers for the multi-digit up/down counter.
package bcd_updown_counter_n_pkg;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] BCD_ZERO   = 4'd0;
    localparam int         MAX_DIGITS = 4;

    // Packed BCD of a non-negative integer, digit 0 in bits [3:0].
    function automatic logic [4*MAX_DIGITS-1:0] int_to_bcd(input int value, input int digits);
        logic [4*MAX_DIGITS-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                r[4*i +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end
        return r;
    endfunction

    // True when every nibble of vec is a legal decimal digit.
    function automatic logic bcd_valid(input logic [4*MAX_DIGITS-1:0] vec);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (vec[4*i +: 4] > BCD_MAX) ok = 1'b0;
        end
        return ok;
    endfunction

    // 10**n, used to bound MAX_VALUE by the digit count.
    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_n_if.sv
// Control and data bundle of the BCD counter; the counter is the slave.
interface bcd_updown_counter_n_if #(
    parameter int DIGITS = 2
);
    logic                  en;
    logic                  up;
    logic                  ld;
    logic [4*DIGITS-1:0]   d;
    logic [4*DIGITS-1:0]   q;
    logic                  co;
    logic                  tc;
    logic                  ld_err;

    modport master (output en, up, ld, d, input q, co, tc, ld_err);
    modport slave  (input en, up, ld, d, output q, co, tc, ld_err);
endinterface

// File: rtl/bcd_digit_step.sv
// One decade of the BCD incrementer/decrementer; carry and borrow ripple upward.
module bcd_digit_step
    import bcd_updown_counter_n_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] nxt,
    output logic       cy,
    output logic       bw
);

    // Next digit value and the carry/borrow passed to the next decade.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        nxt = digit;
        cy  = 1'b0;
        bw  = 1'b0;
        if (inc) begin
            if (digit == BCD_MAX) begin
                nxt = BCD_ZERO;
                cy  = 1'b1;
            end else begin
                nxt = digit + 4'd1;
            end
        end else if (dec) begin
            if (digit == BCD_ZERO) begin
                nxt = BCD_MAX;
                bw  = 1'b1;
            end else begin
                nxt = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter_n.sv
// Multi-digit BCD up/down counter with programmable wrap bound, checked
// parallel load, registered wrap pulse and combinational terminal count.
module bcd_updown_counter_n
    import bcd_updown_counter_n_pkg::*;
#(
    parameter int DIGITS      = 2,
    parameter int MAX_VALUE   = 99,
    parameter int RESET_VALUE = 0
) (
    input  logic                  clk,
    input  logic                  mr,
    bcd_updown_counter_n_if.slave bus
);

    localparam int W = 4 * DIGITS;

    localparam logic [4*MAX_DIGITS-1:0] MAX_BCD16 = int_to_bcd(MAX_VALUE, DIGITS);
    localparam logic [4*MAX_DIGITS-1:0] RST_BCD16 = int_to_bcd(RESET_VALUE, DIGITS);
    localparam logic [W-1:0]            MAX_BCD   = MAX_BCD16[W-1:0];
    localparam logic [W-1:0]            RST_BCD   = RST_BCD16[W-1:0];

    // Refuse to build a counter whose bound or reset value cannot be represented.
    if (DIGITS < 1 || DIGITS > MAX_DIGITS || MAX_VALUE < 1 ||
        MAX_VALUE > pow10(DIGITS) - 1 || RESET_VALUE < 0 || RESET_VALUE > MAX_VALUE) begin : g_param_check
        $error("bcd_updown_counter_n: illegal DIGITS/MAX_VALUE/RESET_VALUE");
    end

    logic [W-1:0]      q_q, q_d;
    logic              co_q, co_d;
    logic              ld_err_q, ld_err_d;
    logic [W-1:0]      step_val;
    logic [DIGITS-1:0] inc_c, dec_c, cy_c, bw_c;
    logic              at_max, at_zero, ld_ok;

    // Ripple chain: digit 0 follows the direction, upper digits follow the carry/borrow below.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign inc_c[i] = bus.up;
            assign dec_c[i] = ~bus.up;
        end else begin : g_upper
            assign inc_c[i] = cy_c[i-1];
            assign dec_c[i] = bw_c[i-1];
        end

        bcd_digit_step u_step (
            .digit (q_q[4*i +: 4]),
            .inc   (inc_c[i]),
            .dec   (dec_c[i]),
            .nxt   (step_val[4*i +: 4]),
            .cy    (cy_c[i]),
            .bw    (bw_c[i])
        );
    end

    // Carry/borrow out of the top decade has no consumer; the wrap bound handles overflow.
    logic unused_chain;
    assign unused_chain = cy_c[DIGITS-1] ^ bw_c[DIGITS-1];

    assign at_max  = (q_q == MAX_BCD);
    assign at_zero = (q_q == '0);
    // With every digit legal, packed BCD orders the same as the decimal value.
    assign ld_ok   = bcd_valid(16'(bus.d)) && (bus.d <= MAX_BCD);

    assign bus.q      = q_q;
    assign bus.co     = co_q;
    assign bus.ld_err = ld_err_q;
    assign bus.tc     = bus.en & ~bus.ld & (bus.up ? at_max : at_zero);

    // Next count: load first, then count with wrap at the bound, else hold.
    always_comb begin
        q_d      = q_q;
        co_d     = 1'b0;
        ld_err_d = 1'b0;
        if (bus.ld) begin
            if (ld_ok) q_d      = bus.d;
            else       ld_err_d = 1'b1;
        end else if (bus.en) begin
            if (bus.up ? at_max : at_zero) begin
                q_d  = bus.up ? '0 : MAX_BCD;
                co_d = 1'b1;
            end else begin
                q_d = step_val;
            end
        end
    end

    // Count, wrap pulse and load-error pulse registers.
    always_ff @(posedge clk or posedge mr) begin
        // NOTE: non-blocking updates so every register samples pre-edge values.
        if (mr) begin
            q_q      <= RST_BCD;
            co_q     <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            co_q     <= co_d;
            ld_err_q <= ld_err_d;
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Self-checking bench: four counters (99/reset 7, 59, and a cascaded 9/9 pair)
// against a decimal-integer model, plus directed literal expectations.
module tb_bcd_updown_counter_n;

    localparam int N = 4;

    logic clk = 1'b0;
    logic mr  = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bcd_updown_counter_n_if #(.DIGITS(2)) a_if ();
    bcd_updown_counter_n_if #(.DIGITS(2)) b_if ();
    bcd_updown_counter_n_if #(.DIGITS(1)) lo_if ();
    bcd_updown_counter_n_if #(.DIGITS(1)) hi_if ();

    assign hi_if.en = lo_if.tc;

    bcd_updown_counter_n #(.DIGITS(2), .MAX_VALUE(99), .RESET_VALUE(7)) u_a  (.clk(clk), .mr(mr), .bus(a_if));
    bcd_updown_counter_n #(.DIGITS(2), .MAX_VALUE(59), .RESET_VALUE(0)) u_b  (.clk(clk), .mr(mr), .bus(b_if));
    bcd_updown_counter_n #(.DIGITS(1), .MAX_VALUE(9),  .RESET_VALUE(0)) u_lo (.clk(clk), .mr(mr), .bus(lo_if));
    bcd_updown_counter_n #(.DIGITS(1), .MAX_VALUE(9),  .RESET_VALUE(0)) u_hi (.clk(clk), .mr(mr), .bus(hi_if));

    // Flattened views of every counter's pins for the model and compare loop.
    logic        m_en [N], m_up [N], m_ld [N], m_co [N], m_tc [N], m_err [N];
    logic [15:0] m_d [N], m_q [N];

    assign m_en[0] = a_if.en;  assign m_up[0] = a_if.up;  assign m_ld[0] = a_if.ld;  assign m_d[0] = 16'(a_if.d);
    assign m_en[1] = b_if.en;  assign m_up[1] = b_if.up;  assign m_ld[1] = b_if.ld;  assign m_d[1] = 16'(b_if.d);
    assign m_en[2] = lo_if.en; assign m_up[2] = lo_if.up; assign m_ld[2] = lo_if.ld; assign m_d[2] = 16'(lo_if.d);
    assign m_en[3] = hi_if.en; assign m_up[3] = hi_if.up; assign m_ld[3] = hi_if.ld; assign m_d[3] = 16'(hi_if.d);
    assign m_q[0] = 16'(a_if.q);  assign m_co[0] = a_if.co;  assign m_tc[0] = a_if.tc;  assign m_err[0] = a_if.ld_err;
    assign m_q[1] = 16'(b_if.q);  assign m_co[1] = b_if.co;  assign m_tc[1] = b_if.tc;  assign m_err[1] = b_if.ld_err;
    assign m_q[2] = 16'(lo_if.q); assign m_co[2] = lo_if.co; assign m_tc[2] = lo_if.tc; assign m_err[2] = lo_if.ld_err;
    assign m_q[3] = 16'(hi_if.q); assign m_co[3] = hi_if.co; assign m_tc[3] = hi_if.tc; assign m_err[3] = hi_if.ld_err;

    function automatic int maxv(input int k);
        case (k)
            0:       return 99;
            1:       return 59;
            default: return 9;
        endcase
    endfunction

    function automatic int rstv(input int k);
        return (k == 0) ? 7 : 0;
    endfunction

    function automatic int ndig(input int k);
        return (k < 2) ? 2 : 1;
    endfunction

    // Decimal value of a nibble vector (nibbles weighted by powers of ten).
    function automatic int dec_val(input logic [15:0] v);
        int r, p;
        r = 0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            r = r + int'(v[4*i +: 4]) * p;
            p = p * 10;
        end
        return r;
    endfunction

    // Legal value for counter k: digits 0..9 within its width and value within bound.
    function automatic bit legal(input logic [15:0] v, input int k);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < ndig(k) && v[4*i +: 4] > 4'd9) ok = 1'b0;
            if (i >= ndig(k) && v[4*i +: 4] != 4'd0) ok = 1'b0;
        end
        return ok && (dec_val(v) <= maxv(k));
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain decimal counter per instance.
    int mv [N];
    bit mco [N], merr [N];

    always @(posedge clk or posedge mr) begin
        for (int k = 0; k < N; k++) begin
            if (mr) begin
                mv[k]   <= rstv(k);
                mco[k]  <= 1'b0;
                merr[k] <= 1'b0;
            end else if (m_ld[k]) begin
                mco[k]  <= 1'b0;
                merr[k] <= !legal(m_d[k], k);
                if (legal(m_d[k], k)) mv[k] <= dec_val(m_d[k]);
            end else if (m_en[k]) begin
                merr[k] <= 1'b0;
                if (m_up[k]) begin
                    mco[k] <= (mv[k] == maxv(k));
                    mv[k]  <= (mv[k] == maxv(k)) ? 0 : mv[k] + 1;
                end else begin
                    mco[k] <= (mv[k] == 0);
                    mv[k]  <= (mv[k] == 0) ? maxv(k) : mv[k] - 1;
                end
            end else begin
                mco[k]  <= 1'b0;
                merr[k] <= 1'b0;
            end
        end
    end

    // Compare every counter against the model on each falling edge.
    always @(negedge clk) begin
        if (!mr) begin
            for (int k = 0; k < N; k++) begin
                check($sformatf("model_q%0d", k),   m_q[k],          to_bcd(mv[k]));
                check($sformatf("model_co%0d", k),  16'(m_co[k]),    16'(mco[k]));
                check($sformatf("model_err%0d", k), 16'(m_err[k]),   16'(merr[k]));
                check($sformatf("model_tc%0d", k),  16'(m_tc[k]),
                      16'(m_en[k] && !m_ld[k] && (m_up[k] ? (mv[k] == maxv(k)) : (mv[k] == 0))));
                check($sformatf("legal_q%0d", k),   16'(legal(m_q[k], k)), 16'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        a_if.en = 0;  a_if.up = 0;  a_if.ld = 0;  a_if.d = '0;
        b_if.en = 0;  b_if.up = 0;  b_if.ld = 0;  b_if.d = '0;
        lo_if.en = 0; lo_if.up = 0; lo_if.ld = 0; lo_if.d = '0;
        hi_if.up = 0; hi_if.ld = 0; hi_if.d = '0;
    endtask

    initial begin
        idle_all();
        #12 mr = 1'b0;
        check("rst_a_q", 16'(a_if.q), 16'h0007);
        check("rst_a_co", 16'(a_if.co), 16'd0);
        check("rst_a_err", 16'(a_if.ld_err), 16'd0);
        check("rst_b_q", 16'(b_if.q), 16'h0000);
        tick();
        check("hold_a_q", 16'(a_if.q), 16'h0007);

        // Up count through the 99 -> 00 wrap.
        a_if.ld = 1; a_if.d = 8'h97; a_if.en = 1; a_if.up = 1;
        tick();
        check("ld97_q", 16'(a_if.q), 16'h0097);
        a_if.ld = 0;
        #1 check("tc_at97", 16'(a_if.tc), 16'd0);
        tick();
        check("up98_q", 16'(a_if.q), 16'h0098);
        tick();
        check("up99_q", 16'(a_if.q), 16'h0099);
        check("tc_at99", 16'(a_if.tc), 16'd1);
        tick();
        check("wrap00_q", 16'(a_if.q), 16'h0000);
        check("wrap00_co", 16'(a_if.co), 16'd1);
        check("tc_at00", 16'(a_if.tc), 16'd0);

        // Asynchronous reset mid-cycle, then the next edge counts normally.
        mr = 1'b1;
        #1;
        check("amr_q", 16'(a_if.q), 16'h0007);
        check("amr_co", 16'(a_if.co), 16'd0);
        mr = 1'b0;
        tick();
        check("post_mr_q", 16'(a_if.q), 16'h0008);
        check("post_mr_co", 16'(a_if.co), 16'd0);

        // Direction change with no skipped value.
        a_if.ld = 1; a_if.d = 8'h10;
        tick();
        check("ld10_q", 16'(a_if.q), 16'h0010);
        a_if.ld = 0;
        tick();
        check("dir11_q", 16'(a_if.q), 16'h0011);
        a_if.up = 0;
        tick();
        check("dir10_q", 16'(a_if.q), 16'h0010);
        tick();
        check("dir09_q", 16'(a_if.q), 16'h0009);
        idle_all();

        // Down count through 00 -> 59 on the modulo-60 counter.
        b_if.ld = 1; b_if.d = 8'h01;
        tick();
        b_if.ld = 0; b_if.en = 1; b_if.up = 0;
        #1 check("tc_b01", 16'(b_if.tc), 16'd0);
        tick();
        check("dn00_q", 16'(b_if.q), 16'h0000);
        check("tc_b00", 16'(b_if.tc), 16'd1);
        tick();
        check("dn59_q", 16'(b_if.q), 16'h0059);
        check("dn59_co", 16'(b_if.co), 16'd1);
        tick();
        check("dn58_q", 16'(b_if.q), 16'h0058);
        check("dn58_co", 16'(b_if.co), 16'd0);
        b_if.ld = 1; b_if.d = 8'h50;
        tick();
        b_if.ld = 0;
        tick();
        check("borrow49_q", 16'(b_if.q), 16'h0049);

        // Loads: priority over count, and rejection of non-BCD / out-of-range values.
        b_if.ld = 1; b_if.d = 8'h42; b_if.en = 1; b_if.up = 1;
        tick();
        check("ld42_q", 16'(b_if.q), 16'h0042);
        check("ld42_err", 16'(b_if.ld_err), 16'd0);
        b_if.d = 8'h3A;
        tick();
        check("ld3A_q", 16'(b_if.q), 16'h0042);
        check("ld3A_err", 16'(b_if.ld_err), 16'd1);
        b_if.ld = 0; b_if.en = 0;
        tick();
        check("err_clear", 16'(b_if.ld_err), 16'd0);
        b_if.ld = 1; b_if.d = 8'h60;
        tick();
        check("ld60_q", 16'(b_if.q), 16'h0042);
        check("ld60_err", 16'(b_if.ld_err), 16'd1);
        b_if.d = 8'h59;
        tick();
        check("ld59_q", 16'(b_if.q), 16'h0059);
        check("ld59_err", 16'(b_if.ld_err), 16'd0);
        idle_all();

        // Cascade: low tc drives high en.
        lo_if.ld = 1; lo_if.d = 4'h9; lo_if.up = 1;
        hi_if.ld = 1; hi_if.d = 4'h0; hi_if.up = 1;
        tick();
        check("cas09", 16'({hi_if.q, lo_if.q}), 16'h0009);
        lo_if.ld = 0; lo_if.en = 1; hi_if.ld = 0;
        #1 check("cas_hi_en", 16'(hi_if.en), 16'd1);
        tick();
        check("cas10", 16'({hi_if.q, lo_if.q}), 16'h0010);
        lo_if.ld = 1; lo_if.d = 4'h9; hi_if.ld = 1; hi_if.d = 4'h9;
        tick();
        check("cas99", 16'({hi_if.q, lo_if.q}), 16'h0099);
        lo_if.ld = 0; hi_if.ld = 0;
        tick();
        check("cas00", 16'({hi_if.q, lo_if.q}), 16'h0000);
        check("cas00_co", 16'({hi_if.co, lo_if.co}), 16'h0003);
        idle_all();
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 10000; c++) begin
            a_if.en = ($urandom_range(0, 3) != 0); a_if.up = 1'($urandom); a_if.ld = ($urandom_range(0, 7) == 0);
            a_if.d  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            b_if.en = ($urandom_range(0, 3) != 0); b_if.up = 1'($urandom); b_if.ld = ($urandom_range(0, 7) == 0);
            b_if.d  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
            lo_if.en = ($urandom_range(0, 3) != 0); lo_if.up = 1'($urandom); lo_if.ld = ($urandom_range(0, 7) == 0);
            lo_if.d  = 4'($urandom_range(0, 11));
            hi_if.up = 1'($urandom); hi_if.ld = ($urandom_range(0, 7) == 0);
            hi_if.d  = 4'($urandom_range(0, 11));
            tick();
        end

        idle_all();
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
